mem_xbar: RTL
=============

MEM_XBAR -- requirements
Module: mem_xbar

Interface
REQ-001 SHALL have parameter NSLV, default 4, number of slave ports (1..8).
REQ-002 SHALL have parameter BASE_ADDR, default {32'h8000_0000, 32'h1000_0000, 32'h0200_0000, 32'h0000_0000} (index 3..0), inclusive region base per slave.
REQ-003 SHALL have parameter TOP_ADDR, default {32'h9000_0000, 32'h1000_1000, 32'h0200_C000, 32'h0010_0000}, exclusive region top per slave.
REQ-004 SHALL have parameter RR_EN, default 1; 1 = round-robin per slave, 0 = fixed dmemory priority.
REQ-005 SHALL have ports: clock in 1 system clock; reset in 1 synchronous, active-high.
REQ-006 SHALL have imemory_valid/instr in 1, imemory_addr/wdata in 32, imemory_wstrb in 4, imemory_rdata out 32, imemory_ready out 1, imemory_error out 1: instruction master port.
REQ-007 SHALL have the identical dmemory_* set: data master port.
REQ-008 SHALL have s_valid/s_instr out NSLV, s_addr/s_wdata out NSLV*32, s_wstrb out NSLV*4, s_rdata in NSLV*32, s_ready in NSLV: slave ports, slice j = slave j.

Function
REQ-009 Master valid SHALL be a one-cycle strobe; master issues no new request before its ready; module SHALL hold at most one outstanding request per master.
REQ-010 Decode: slave j hit iff BASE_ADDR[j] <= addr < TOP_ADDR[j]; overlapping regions SHALL resolve to lowest j; s_addr = addr - BASE_ADDR[j], 32-bit modular.
REQ-011 Per-master FSM states IDLE, WAIT, BUSY, ERR; reset state IDLE.
REQ-012 Slave j is free in a cycle if it has no owner or s_ready[j]=1 that cycle; each slave SHALL have at most one owner.
REQ-013 IDLE + valid + mapped + slave free + arbitration won -> s_valid[j]=1 same cycle (combinational) with that master's instr/addr offset/wdata/wstrb, owner set, -> BUSY.
REQ-014 IDLE + valid + mapped + slave not free or arbitration lost -> request captured in per-master 1-entry buffer, -> WAIT; no s_valid that cycle.
REQ-015 WAIT -> issue buffered request when slave free and arbitration won, s_valid one cycle, -> BUSY; master inputs ignored while WAIT.
REQ-016 BUSY + s_ready[owned]=1 -> master ready=1, rdata=s_rdata[j], error=0 same cycle, owner cleared, -> IDLE; new valid in that cycle SHALL be accepted per REQ-013/014.
REQ-017 IDLE + valid + unmapped -> ERR; next cycle ready=1, error=1, rdata=0, -> IDLE; no slave strobed.
REQ-018 Contention (both masters requesting same free slave same cycle, from IDLE or WAIT): RR_EN=1 grants master not granted last on that slave (initial pointer favours dmemory); RR_EN=0 grants dmemory; loser -> WAIT.
REQ-019 Round-robin pointer per slave SHALL update only on grant.
REQ-020 Masters targeting different slaves SHALL proceed concurrently, independently.
REQ-021 s_ready[j] with no owner SHALL be ignored; ready/error outputs SHALL be 0 when not responding; all s_* outputs 0 when not strobing.

Reset
REQ-022 reset=1 at clock edge -> FSMs IDLE, owners cleared, buffers invalid, RR pointers favour dmemory; all valid/ready/error outputs 0, data outputs 0.
REQ-023 Reset mid-transaction SHALL abandon it; the slave's later s_ready SHALL be dropped per REQ-021.

Verification
V-1 dmem read 0x1000_0004 cycle 0, s_ready[2] cycle 2 with rdata 0x41 -> s_valid[2]=1, s_addr=0x4 cycle 0; dmemory_ready=1, rdata=0x41 cycle 2.
V-2 imem and dmem both to 0x8000_0000 cycle 0, RR_EN=1 -> slave 3 serves dmem first; imem strobed in cycle dmem ready returns; next contention grants imem.
V-3 RR_EN=0, repeat V-2 twice -> dmem granted both times; imem always WAIT then served.
V-4 dmem to 0x2000_0000 (unmapped) cycle 0 -> cycle 1 dmemory_ready=1, error=1, rdata=0; no s_valid.
V-5 imem to 0x0000_0100, dmem to 0x0200_4000 same cycle -> s_valid[0] and s_valid[1] both cycle 0, s_addr 0x100 and 0x4000.
V-6 reset=1 while dmem BUSY on slave 0, s_ready[0] after reset -> no dmemory_ready; next dmem request to slave 0 issues immediately.

Source files
------------

// File: rtl/mem_xbar_if.sv
// rtl/mem_xbar_if.sv - master-side request/response bus of the memory crossbar
// Ports: valid (1-cycle request strobe), instr, addr, wdata, wstrb from the
// master; rdata, ready, error back to the master.
// Modports: master = requester side, slave = crossbar side.
interface mem_xbar_if;
    logic        valid;
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    logic        ready;
    logic        error;

    modport master (output valid, instr, addr, wdata, wstrb, input rdata, ready, error);
    modport slave  (input valid, instr, addr, wdata, wstrb, output rdata, ready, error);
endinterface

// File: rtl/mem_xbar.sv
// rtl/mem_xbar.sv - two-master (instruction/data) to NSLV-slave address-decoded crossbar
// Ports: clock, reset (sync, active-high); imemory/dmemory master buses
// (mem_xbar_if.slave); s_valid/s_instr/s_addr/s_wdata/s_wstrb per-slave
// request strobes (slice j = slave j); s_rdata/s_ready per-slave responses.
module mem_xbar #(
    parameter int                    NSLV      = 4,
    parameter logic [NSLV-1:0][31:0] BASE_ADDR = {32'h8000_0000, 32'h1000_0000, 32'h0200_0000, 32'h0000_0000},
    parameter logic [NSLV-1:0][31:0] TOP_ADDR  = {32'h9000_0000, 32'h1000_1000, 32'h0200_C000, 32'h0010_0000},
    parameter bit                    RR_EN     = 1'b1
) (
    input  logic               clock,
    input  logic               reset,
    mem_xbar_if.slave          imemory,
    mem_xbar_if.slave          dmemory,
    output logic [NSLV-1:0]    s_valid,
    output logic [NSLV-1:0]    s_instr,
    output logic [NSLV*32-1:0] s_addr,
    output logic [NSLV*32-1:0] s_wdata,
    output logic [NSLV*4-1:0]  s_wstrb,
    input  logic [NSLV*32-1:0] s_rdata,
    input  logic [NSLV-1:0]    s_ready
);
    localparam int SW = (NSLV > 1) ? $clog2(NSLV) : 1;
    localparam int IM = 0;
    localparam int DM = 1;

    typedef enum logic [1:0] {IDLE, WAIT, BUSY, ERR} state_t;

    state_t             state [2];
    logic [1:0][SW-1:0] slv_q;      // target slave while WAIT or BUSY
    logic [1:0]         buf_instr;
    logic [1:0][31:0]   buf_addr;   // already converted to slave offset
    logic [1:0][31:0]   buf_wdata;
    logic [1:0][3:0]    buf_wstrb;
    logic [NSLV-1:0]    own_q;      // slave has an outstanding request
    logic [NSLV-1:0]    last_q;     // 1 = dmemory won the last contention

    logic [1:0]         in_valid, in_instr;
    logic [1:0][31:0]   in_addr, in_wdata;
    logic [1:0][3:0]    in_wstrb;

    assign in_valid = {dmemory.valid, imemory.valid};
    assign in_instr = {dmemory.instr, imemory.instr};
    assign in_addr  = {dmemory.addr,  imemory.addr};
    assign in_wdata = {dmemory.wdata, imemory.wdata};
    assign in_wstrb = {dmemory.wstrb, imemory.wstrb};

    logic [1:0]         hit, done, accept, req, grant, free_sel, iss_instr;
    logic [1:0][SW-1:0] dec_slv, req_slv;
    logic [1:0][31:0]   dec_off, rd_sel, iss_addr, iss_wdata;
    logic [1:0][3:0]    iss_wstrb;
    logic [NSLV-1:0]    free;
    logic               contend, last_sel, winner;

    assign free = ~own_q | s_ready;

    always_comb begin
        contend  = 1'b0;
        last_sel = 1'b0;
        winner   = 1'b1;
        for (int m = 0; m < 2; m++) begin
            hit[m]     = 1'b0;
            dec_slv[m] = '0;
            dec_off[m] = '0;
            // Scan high to low so the lowest matching region wins on overlap.
            for (int j = NSLV - 1; j >= 0; j--) begin
                if (in_addr[m] >= BASE_ADDR[j] && in_addr[m] < TOP_ADDR[j]) begin
                    hit[m]     = 1'b1;
                    dec_slv[m] = SW'(j);
                    dec_off[m] = in_addr[m] - BASE_ADDR[j];
                end
            end
            done[m]   = 1'b0;
            rd_sel[m] = '0;
            for (int j = 0; j < NSLV; j++) begin
                if (slv_q[m] == SW'(j)) begin
                    done[m]   = (state[m] == BUSY) && s_ready[j];
                    rd_sel[m] = s_rdata[j*32 +: 32];
                end
            end
            // A master finishing this cycle may present its next request at once.
            accept[m]    = (state[m] == IDLE) || done[m];
            req[m]       = (accept[m] && in_valid[m] && hit[m]) || (state[m] == WAIT);
            req_slv[m]   = (state[m] == WAIT) ? slv_q[m] : dec_slv[m];
            iss_instr[m] = (state[m] == WAIT) ? buf_instr[m] : in_instr[m];
            iss_addr[m]  = (state[m] == WAIT) ? buf_addr[m]  : dec_off[m];
            iss_wdata[m] = (state[m] == WAIT) ? buf_wdata[m] : in_wdata[m];
            iss_wstrb[m] = (state[m] == WAIT) ? buf_wstrb[m] : in_wstrb[m];
            free_sel[m]  = 1'b0;
            for (int j = 0; j < NSLV; j++) begin
                if (req_slv[m] == SW'(j)) begin
                    free_sel[m] = free[j];
                end
            end
        end
        contend = req[IM] && req[DM] && (req_slv[IM] == req_slv[DM]);
        for (int j = 0; j < NSLV; j++) begin
            if (req_slv[DM] == SW'(j)) begin
                last_sel = last_q[j];
            end
        end
        winner = RR_EN ? ~last_sel : 1'b1;
        for (int m = 0; m < 2; m++) begin
            grant[m] = req[m] && free_sel[m] && (!contend || (winner == m[0]));
        end
    end

    always_comb begin
        s_valid = '0;
        s_instr = '0;
        s_addr  = '0;
        s_wdata = '0;
        s_wstrb = '0;
        for (int j = 0; j < NSLV; j++) begin
            for (int m = 0; m < 2; m++) begin
                if (grant[m] && req_slv[m] == SW'(j)) begin
                    s_valid[j]          = 1'b1;
                    s_instr[j]          = iss_instr[m];
                    s_addr[j*32 +: 32]  = iss_addr[m];
                    s_wdata[j*32 +: 32] = iss_wdata[m];
                    s_wstrb[j*4 +: 4]   = iss_wstrb[m];
                end
            end
        end
    end

    assign imemory.ready = done[IM] || (state[IM] == ERR);
    assign imemory.error = (state[IM] == ERR);
    assign imemory.rdata = done[IM] ? rd_sel[IM] : 32'h0;
    assign dmemory.ready = done[DM] || (state[DM] == ERR);
    assign dmemory.error = (state[DM] == ERR);
    assign dmemory.rdata = done[DM] ? rd_sel[DM] : 32'h0;

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int m = 0; m < 2; m++) begin
                state[m] <= IDLE;
            end
            slv_q     <= '0;
            buf_instr <= '0;
            buf_addr  <= '0;
            buf_wdata <= '0;
            buf_wstrb <= '0;
            own_q     <= '0;
            last_q    <= '0;
        end else begin
            for (int j = 0; j < NSLV; j++) begin
                // Ready on an unowned slave clears nothing that is set.
                if (s_ready[j]) begin
                    own_q[j] <= 1'b0;
                end
                if ((grant[IM] && req_slv[IM] == SW'(j)) || (grant[DM] && req_slv[DM] == SW'(j))) begin
                    own_q[j] <= 1'b1;
                end
                // The pointer tracks arbitration outcomes only, not uncontended issues.
                if (contend && free[j] && req_slv[DM] == SW'(j)) begin
                    last_q[j] <= grant[DM];
                end
            end
            for (int m = 0; m < 2; m++) begin
                case (state[m])
                    WAIT: if (grant[m]) state[m] <= BUSY;
                    ERR:  state[m] <= IDLE;
                    default: begin
                        if (accept[m]) begin
                            if (in_valid[m] && !hit[m]) begin
                                state[m] <= ERR;
                            end else if (in_valid[m]) begin
                                slv_q[m] <= dec_slv[m];
                                if (grant[m]) begin
                                    state[m] <= BUSY;
                                end else begin
                                    buf_instr[m] <= in_instr[m];
                                    buf_addr[m]  <= dec_off[m];
                                    buf_wdata[m] <= in_wdata[m];
                                    buf_wstrb[m] <= in_wstrb[m];
                                    state[m]     <= WAIT;
                                end
                            end else begin
                                state[m] <= IDLE;
                            end
                        end
                    end
                endcase
            end
        end
    end
endmodule
